// File: rtl/tetris_pkg.sv
// Shared Tetris definitions: scheduler state encoding, level-to-gravity period table
// and the frame rate of the tick generator.
package tetris_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    PENDING = 2'd2
  } state_t;

  localparam int FRAMES_PER_SEC = 60;

  // Frames per row drop, indexed by level 0..15
  localparam logic [7:0] LEVEL_PERIOD [16] = '{
    8'd48, 8'd43, 8'd38, 8'd33, 8'd28, 8'd23, 8'd18, 8'd13,
    8'd8,  8'd6,  8'd5,  8'd5,  8'd5,  8'd4,  8'd4,  8'd4
  };

endpackage

// File: rtl/gravity_period_lut.sv
// Combinational frames-per-row selection: the soft-drop period overrides the level table.
module gravity_period_lut #(
  parameter int CNT_W       = 6,
  parameter int SOFT_PERIOD = 2
) (
  input  logic [3:0]       level,
  input  logic             soft_drop,
  output logic [CNT_W-1:0] period
);
  import tetris_pkg::*;

  always_comb begin
    period = CNT_W'(LEVEL_PERIOD[level]);
    if (soft_drop) period = CNT_W'(SOFT_PERIOD);
  end

endmodule

// File: rtl/gravity_scheduler.sv
// Turns 60 Hz frame ticks into req/ack row-drop requests for the falling piece.
// Define GRAVITY_LOCK_DELAY_EN to build the lock-delay timer that drives lock_req.
module gravity_scheduler #(
  parameter int CNT_W       = 6,
  parameter int SOFT_PERIOD = 2,
  parameter int LOCK_FRAMES = 30
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       enable,
  input  logic       frame_tick,
  input  logic       restart,
  input  logic [3:0] level,
  input  logic       soft_drop,
  input  logic       landed,
  input  logic       drop_ack,
  output logic       drop_req,
  output logic       lock_req
);
  import tetris_pkg::*;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] period;
  logic             frozen;

  gravity_period_lut #(
    .CNT_W      (CNT_W),
    .SOFT_PERIOD(SOFT_PERIOD)
  ) u_period_lut (
    .level    (level),
    .soft_drop(soft_drop),
    .period   (period)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Compare with >= so a period shortened mid-count fires on the very next tick
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (!enable) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else if (restart) begin
      state_n = COUNT;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_n = COUNT;
          cnt_n   = '0;
        end
        COUNT: begin
          if (frame_tick && !frozen) begin
            if (({1'b0, cnt} + 1'b1) >= {1'b0, period}) begin
              state_n = PENDING;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end
        end
        PENDING: begin
          cnt_n = '0;
          if (drop_ack) state_n = COUNT;
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_comb begin
    drop_req = (state == PENDING);
  end

`ifdef GRAVITY_LOCK_DELAY_EN
  localparam int LOCK_W = $clog2(LOCK_FRAMES + 1);

  logic [LOCK_W-1:0] lock_cnt, lock_cnt_n;
  logic              lock_req_q, lock_req_n;

  assign frozen = landed;

  always_ff @(posedge clk) begin
    if (!resetn || !enable) begin
      lock_cnt   <= '0;
      lock_req_q <= 1'b0;
    end else begin
      lock_cnt   <= lock_cnt_n;
      lock_req_q <= lock_req_n;
    end
  end

  // Lock time only accrues while resting in COUNT; lifting off the stack forfeits it
  always_comb begin
    lock_cnt_n = lock_cnt;
    lock_req_n = 1'b0;
    if (restart || !landed) begin
      lock_cnt_n = '0;
    end else if (state == COUNT && frame_tick) begin
      if (int'(lock_cnt) + 1 >= LOCK_FRAMES) begin
        lock_cnt_n = '0;
        lock_req_n = 1'b1;
      end else begin
        lock_cnt_n = lock_cnt + 1'b1;
      end
    end
  end

  assign lock_req = lock_req_q;
`else
  localparam int unused_lock_frames = LOCK_FRAMES;
  logic unused_landed;

  assign unused_landed = landed;
  assign frozen        = 1'b0;
  assign lock_req      = 1'b0;
`endif

endmodule

// File: tb/tb_gravity_scheduler.sv
// Self-checking bench for gravity_scheduler: directed scenarios then randomized traffic,
// all compared against a cycle-level behavioural model built from the period rules.
module tb_gravity_scheduler;

  localparam int CNT_W       = 6;
  localparam int SOFT_PERIOD = 2;
  localparam int LOCK_FRAMES = 30;

  logic       clk = 1'b0;
  logic       resetn, enable, frame_tick, restart, soft_drop, landed, drop_ack;
  logic [3:0] level;
  logic       drop_req, lock_req;

  int checks = 0;
  int errors = 0;

  bit m_run, m_pend, m_lock_req;
  int m_ticks, m_lock;

  always #10 clk = ~clk;

  gravity_scheduler #(
    .CNT_W      (CNT_W),
    .SOFT_PERIOD(SOFT_PERIOD),
    .LOCK_FRAMES(LOCK_FRAMES)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .enable    (enable),
    .frame_tick(frame_tick),
    .restart   (restart),
    .level     (level),
    .soft_drop (soft_drop),
    .landed    (landed),
    .drop_ack  (drop_ack),
    .drop_req  (drop_req),
    .lock_req  (lock_req)
  );

  function automatic int ref_period(input logic [3:0] lv, input logic sd);
    if (sd) return SOFT_PERIOD;
    if (lv <= 4'd8) return 48 - 5 * int'(lv);
    if (lv == 4'd9) return 6;
    if (lv <= 4'd12) return 5;
    return 4;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Expected outputs after one clock edge, given the inputs seen at that edge
  task automatic modelStep();
    bit resting;
    resting = 1'b0;
`ifdef GRAVITY_LOCK_DELAY_EN
    resting = landed;
`endif
    if (!resetn || !enable) begin
      m_run = 0; m_pend = 0; m_ticks = 0; m_lock = 0; m_lock_req = 0;
    end else begin
      m_lock_req = 0;
      if (restart) begin
        m_run = 1; m_pend = 0; m_ticks = 0; m_lock = 0;
      end else if (!m_run) begin
        m_run = 1; m_ticks = 0;
      end else if (m_pend) begin
        if (drop_ack) m_pend = 0;
      end else if (resting) begin
        if (frame_tick) begin
          m_lock++;
          if (m_lock >= LOCK_FRAMES) begin
            m_lock = 0;
            m_lock_req = 1;
          end
        end
      end else if (frame_tick) begin
        m_ticks++;
        if (m_ticks >= ref_period(level, soft_drop)) begin
          m_ticks = 0;
          m_pend = 1;
        end
      end
`ifdef GRAVITY_LOCK_DELAY_EN
      if (!landed) m_lock = 0;
`endif
    end
  endtask

  task automatic applyStimulus(input logic tick, input logic ack, input logic rs);
    frame_tick = tick;
    drop_ack   = ack;
    restart    = rs;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkOutput("model_drop_req", drop_req, m_pend);
    checkOutput("model_lock_req", lock_req, m_lock_req);
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    resetn = 0; enable = 1; frame_tick = 0; restart = 0;
    soft_drop = 0; landed = 0; drop_ack = 0; level = 4'd0;
    m_run = 0; m_pend = 0; m_lock_req = 0; m_ticks = 0; m_lock = 0;
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("reset_drop_req", drop_req, 1'b0);
    checkOutput("reset_lock_req", lock_req, 1'b0);
    resetn = 1;
    applyStimulus(1'b0, 1'b0, 1'b0);

    $display("[TB] level 0 period and ack handshake");
    run_ticks(47);
    checkOutput("l0_before_48", drop_req, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("l0_rise", drop_req, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("l0_held", drop_req, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("l0_ack_clear", drop_req, 1'b0);
    run_ticks(47);
    checkOutput("l0_second_early", drop_req, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("l0_second_rise", drop_req, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);

    $display("[TB] soft drop shortens period mid-count");
    level = 4'd9;
    run_ticks(3);
    checkOutput("l9_cnt3_idle", drop_req, 1'b0);
    soft_drop = 1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("soft_fire", drop_req, 1'b1);
    soft_drop = 0;
    applyStimulus(1'b0, 1'b1, 1'b0);

    $display("[TB] ticks ignored while pending");
    level = 4'd8;
    run_ticks(7);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("l8_rise", drop_req, 1'b1);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("pend_ticks_ignored", drop_req, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("ack_with_tick", drop_req, 1'b0);
    run_ticks(7);
    checkOutput("cnt_zero_after_ack", drop_req, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("l8_next_rise", drop_req, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);

    $display("[TB] restart and enable");
    level = 4'd0;
    run_ticks(20);
    applyStimulus(1'b0, 1'b0, 1'b1);
    run_ticks(47);
    checkOutput("restart_early", drop_req, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("restart_rise", drop_req, 1'b1);
    enable = 0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("disable_clear", drop_req, 1'b0);
    enable = 1;
    applyStimulus(1'b0, 1'b0, 1'b0);

    $display("[TB] reset during pending");
    level = 4'd15;
    run_ticks(3);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("l15_rise", drop_req, 1'b1);
    resetn = 0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("midreset_drop", drop_req, 1'b0);
    checkOutput("midreset_lock", lock_req, 1'b0);
    resetn = 1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    run_ticks(3);
    checkOutput("idle_tick_ignored", drop_req, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("after_reset_rise", drop_req, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);

    $display("[TB] landed behaviour");
    level = 4'd0;
    landed = 1;
`ifdef GRAVITY_LOCK_DELAY_EN
    run_ticks(29);
    checkOutput("lock_early", lock_req, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("lock_pulse", lock_req, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("lock_single", lock_req, 1'b0);
    checkOutput("lock_no_drop", drop_req, 1'b0);
    run_ticks(29);
    landed = 0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    landed = 1;
    run_ticks(29);
    checkOutput("lock_restarted", lock_req, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("lock_pulse2", lock_req, 1'b1);
`else
    run_ticks(47);
    checkOutput("landed_no_lock", lock_req, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("landed_ignored", drop_req, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);
`endif
    landed = 0;

    $display("[TB] randomized traffic");
    for (int i = 0; i < 3000; i++) begin
      logic tick, ack, rs;
      resetn = ($urandom % 300) != 0;
      enable = ($urandom % 200) != 0;
      if ($urandom % 50 == 0) level = 4'($urandom % 16);
      if ($urandom % 40 == 0) soft_drop = ~soft_drop;
      if ($urandom % 30 == 0) landed = ~landed;
      tick = ($urandom % 3) == 0;
      ack  = m_pend ? (($urandom % 4) == 0) : (($urandom % 16) == 0);
      rs   = ($urandom % 64) == 0;
      applyStimulus(tick, ack, rs);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gravity_scheduler.md
# gravity_scheduler

Converts the 60 Hz frame-tick pulse into row-drop requests for the falling tetromino, using a level-dependent frames-per-row period plus a soft-drop override. Sits directly downstream of the 1/60 s tick generator and upstream of the game-control FSM, which consumes `drop_req` through a req/ack handshake. An optional lock-delay timer issues `lock_req` after a piece has rested on the stack for a fixed number of frames.

## Interface
- `CNT_W`, default 6: frame counter width; must hold the largest period (48).
- `SOFT_PERIOD`, default 2: frames per row while `soft_drop` is held.
- `LOCK_FRAMES`, default 30: lock delay in frames (macro build only).
- `clk`  in  1  system clock, 50 MHz.
- `resetn`  in  1  reset; synchronous, active-low.
- `enable`  in  1  game running; low parks the block in IDLE.
- `frame_tick`  in  1  single-cycle pulse, one per 1/60 s.
- `restart`  in  1  one-cycle pulse on new-piece spawn; clears timers.
- `level`  in  4  current level, 0..15.
- `soft_drop`  in  1  down key held.
- `landed`  in  1  piece cannot move down (used only with the macro).
- `drop_ack`  in  1  game FSM has moved the piece one row.
- `drop_req`  out  1  request one row drop; held until acked.
- `lock_req`  out  1  one-cycle pulse: lock piece now.

## Operation
- Period select: `period = soft_drop ? SOFT_PERIOD : lut(level)`. LUT: 0:48, 1:43, 2:38, 3:33, 4:28, 5:23, 6:18, 7:13, 8:8, 9:6, 10–12:5, 13–15:4. Evaluated every cycle, never latched.
- States: IDLE, COUNT, PENDING.
- Priority each cycle: `!resetn` > `!enable` > `restart` > state logic.
- `!enable` or reset: state IDLE, `cnt`=0, `drop_req`=0, lock counter 0, `lock_req`=0.
- IDLE → COUNT on the first cycle `enable`=1; `cnt`=0.
- `restart`: `cnt`=0, lock counter 0, `drop_req`=0, state COUNT.
- COUNT, `frame_tick`: if `cnt+1 >= period` then `cnt`=0, state PENDING; else `cnt`=`cnt+1`. Compare uses `>=`, so a period shortened mid-count (level up, soft drop pressed) fires on the next tick.
- PENDING: `drop_req`=1; frame ticks ignored, `cnt` held at 0. On `drop_ack` → COUNT.
- `drop_ack` outside PENDING is ignored.
- `drop_ack` and `frame_tick` in the same PENDING cycle: ack taken, tick discarded.
- No arithmetic wrap: `cnt` never exceeds `period-1`.

## Timing
- `drop_req` is registered: it rises on the clk edge after the completing `frame_tick` cycle (1-cycle latency), and falls on the edge after the `drop_ack` cycle.
- The counter restarts from 0 on the ack edge; the next request comes exactly `period` ticks after the ack.
- `lock_req` is registered: it is high for exactly one cycle, on the edge after the tick that reaches `LOCK_FRAMES`.
- Reset value of every output is 0.

## Configuration
- `GRAVITY_LOCK_DELAY_EN` defined:
  - While `landed`=1 and the state is COUNT, the lock counter increments on each `frame_tick`.
  - The gravity `cnt` is frozen while `landed`=1, so no new `drop_req` is issued.
  - When the lock counter reaches `LOCK_FRAMES`, `lock_req` pulses and the lock counter clears.
  - `landed`=0 clears the lock counter immediately.
  - `restart` clears the lock counter.
- Not defined: `landed` is ignored, `lock_req` is tied to 0, and no lock counter is built. Ports are identical in both builds.

## Structure
- The shared package `tetris_pkg` holds:
  - the state enum (IDLE/COUNT/PENDING);
  - the 16-entry level period table;
  - `FRAMES_PER_SEC`=60.
- Sub-module `gravity_period_lut`: combinational `level`, `soft_drop` → `period`. It is the only natural split.

## Test plan
- Level 0, no soft drop, ack 3 cycles after each req: 48 ticks → `drop_req`=1 one cycle after the 48th tick; it stays high for the 3 cycles and clears the cycle after the ack; the next req comes 48 ticks after the ack.
- Level 9, `cnt`=3, then `soft_drop`=1 → `drop_req` on the next tick (`cnt+1`=4 ≥ 2).
- In PENDING, hold off ack for 10 ticks, then assert ack and tick together → exactly one req; `cnt`=0 after the ack.
- `restart` with `cnt`=20 at level 0 → `cnt`=0; the next req comes 48 ticks later. `enable`=0 mid-PENDING → `drop_req` falls next cycle.
- `resetn`=0 for one cycle during PENDING → all outputs 0 next cycle, state IDLE.
- Macro build: `landed`=1 for 30 ticks → `lock_req` single pulse and no `drop_req`; `landed` dropped at tick 29 and reasserted → the count restarts from 0.
